ex_mem_pipe_reg: RTL and testbench
==================================

// Module: ex_mem_pipe_reg
// PURPOSE
//  EX->MEM pipeline register with valid/ready handshake. Captures the EX-stage result, store data and
//  write-back controls, and presents them to the MEM stage (data cache port, may stall on coherence
//  traffic). Its *_MEM control outputs also feed the forwarding unit directly.
//  Bubbles are never visible as register writes.
// PARAMETERS
//  XLEN   32  datapath width (ALU result, store data, PC+4)
// PORTS
//  i_clk            in   1     clock, all state on rising edge
//  i_rst            in   1     synchronous reset, active-high
//  i_flush          in   1     kill all held entries (branch/exception redirect)
//  i_valid_EX       in   1     EX offers an instruction
//  o_ready_EX       out  1     block can accept this cycle
//  i_alu_result_EX  in   XLEN  ALU result / memory address
//  i_rs2_data_EX    in   XLEN  store data
//  i_pc4_EX         in   XLEN  PC+4 for jump link
//  i_write_reg_EX   in   5     destination register
//  i_ctrl_EX        in   9     {regwrite,memtoreg,memread,memwrite,wb,slt,jump,funct3[1:0]}
//  o_valid_MEM      out  1     MEM entry valid
//  i_ready_MEM      in   1     MEM consumes entry this cycle
//  o_alu_result_MEM out  XLEN  held payload
//  o_rs2_data_MEM   out  XLEN  held payload
//  o_pc4_MEM        out  XLEN  held payload
//  o_write_reg_MEM  out  5     held destination register
//  o_regwrite_MEM   out  1     ctrl.regwrite AND o_valid_MEM
//  o_memtoreg_MEM, o_memread_MEM, o_memwrite_MEM, o_wb_MEM, o_slt_MEM, o_jump_MEM  out 1 each; memread/memwrite ANDed with valid
//  o_funct3_MEM     out  2     access size
// BEHAVIOUR
//  - Reset (i_rst=1 at edge): all valid flags 0, all outputs 0; o_ready_EX=0 while i_rst=1; inputs ignored.
//  - Accept = i_valid_EX & o_ready_EX. Emit = o_valid_MEM & i_ready_MEM.
//  - Main register M drives outputs. Load M when accepted and (M empty or Emit). Latency 1 cycle EX->MEM.
//  - Emit without accept: M valid->0, payload held (don't care).
//  - M full, not emitted, accept: behaviour per SKID_BUFFER_EN below.
//  - i_flush: next cycle all entries invalid; Accept in same cycle discarded; overrides Emit/loads.
//    Flush and i_rst both beat handshake.
//  - Payload registers update only on load (no enable toggling when stalled); outputs stable while
//    o_valid_MEM & !i_ready_MEM.
//  - o_regwrite_MEM/o_memread_MEM/o_memwrite_MEM are 0 whenever o_valid_MEM=0 (forwarding sees no match on bubble).
//  - No combinational path i_valid_EX -> o_valid_MEM.
// CONFIGURATION
//  SKID_BUFFER_EN defined: second register S (skid). o_ready_EX = !S.valid & !i_rst (registered, no
//    path from i_ready_MEM). Accept while M full and !Emit -> load S. Emit with S valid -> S moves to M,
//    S.valid->0. Full throughput, 2 entries max.
//  SKID_BUFFER_EN undefined: single register M; o_ready_EX = (!M.valid | i_ready_MEM) & !i_rst
//    (combinational from i_ready_MEM). Accept never occurs while M full and not emitted.
// TESTING
//  1 reset: i_rst=1 2 cycles with i_valid_EX=1 -> o_valid_MEM=0, o_regwrite_MEM=0, o_ready_EX=0; after release o_ready_EX=1.
//  2 streaming: i_ready_MEM=1, 4 back-to-back writes rd=1..4 alu=0x10..0x40 -> same order on outputs, 1-cycle latency, no gaps.
//  3 backpressure: i_ready_MEM=0 for 3 cycles mid-stream -> outputs held (alu=0x20 stable); (EN) o_ready_EX drops after 1 extra accept,
//    no loss/duplication after release.
//  4 flush: S and M full, i_flush=1 with i_valid_EX=1 -> next cycle o_valid_MEM=0, o_regwrite_MEM=0; flushed rd never appears.
//  5 bubble vs forward: entry rd=5 regwrite=1 then i_valid_EX=0 -> o_regwrite_MEM=1 one cycle then 0 while o_write_reg_MEM may stay 5.
//  6 rd=0 / slt/jump ctrl: ctrl bits pass unaltered (slt=1 -> o_slt_MEM=1, jump=1 with pc4=0x104 -> o_pc4_MEM=0x104).

Source files
------------

// File: rtl/ex_mem_pipe_reg.sv
// ex_mem_pipe_reg: EX->MEM pipeline register with a valid/ready handshake.
// It holds the EX-stage result, the store data, PC+4 and the write-back
// controls for the MEM stage. The forwarding unit also reads the *_MEM
// control outputs directly, so regwrite, memread and memwrite are gated
// with o_valid_MEM. A bubble therefore never looks like a register write.
//
// Optional feature: `define SKID_BUFFER_EN adds a second (skid) entry.
//   - o_ready_EX then comes straight from a register.
//   - The block sustains full throughput with up to 2 entries in flight.
// Default build (macro undefined): one entry only.
//   - o_ready_EX is combinational from i_ready_MEM.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-high reset
//   i_flush               drop every held entry (redirect)
//   i_valid_EX/o_ready_EX EX-side handshake
//   i_*_EX                payload: alu result, store data, pc+4, rd, ctrl[8:0]
//                         ctrl = {regwrite,memtoreg,memread,memwrite,wb,slt,jump,funct3[1:0]}
//   o_valid_MEM/i_ready_MEM MEM-side handshake
//   o_*_MEM               held payload and decoded control bits
module ex_mem_pipe_reg #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_flush,
    input  logic            i_valid_EX,
    output logic            o_ready_EX,
    input  logic [XLEN-1:0] i_alu_result_EX,
    input  logic [XLEN-1:0] i_rs2_data_EX,
    input  logic [XLEN-1:0] i_pc4_EX,
    input  logic [4:0]      i_write_reg_EX,
    input  logic [8:0]      i_ctrl_EX,
    output logic            o_valid_MEM,
    input  logic            i_ready_MEM,
    output logic [XLEN-1:0] o_alu_result_MEM,
    output logic [XLEN-1:0] o_rs2_data_MEM,
    output logic [XLEN-1:0] o_pc4_MEM,
    output logic [4:0]      o_write_reg_MEM,
    output logic            o_regwrite_MEM,
    output logic            o_memtoreg_MEM,
    output logic            o_memread_MEM,
    output logic            o_memwrite_MEM,
    output logic            o_wb_MEM,
    output logic            o_slt_MEM,
    output logic            o_jump_MEM,
    output logic [1:0]      o_funct3_MEM
);

    typedef struct packed {
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rd;
        logic [8:0]      ctrl;
    } entry_t;

    entry_t in_ent;
    entry_t m_q;
    logic   m_vld;
    logic   m_vld_n;
    logic   m_load;
    logic   accept;
    logic   emit;

    assign in_ent = '{alu: i_alu_result_EX, rs2: i_rs2_data_EX, pc4: i_pc4_EX,
                      rd: i_write_reg_EX, ctrl: i_ctrl_EX};

    assign accept = i_valid_EX & o_ready_EX;
    assign emit   = m_vld & i_ready_MEM;

`ifdef SKID_BUFFER_EN
    entry_t s_q;
    logic   s_vld;
    logic   s_vld_n;
    logic   s_load;
    logic   m_from_s;

    // The decision depends only on S occupancy, so i_ready_MEM never
    // reaches EX combinationally.
    assign o_ready_EX = !s_vld & !i_rst;

    always_comb begin
        m_load   = 1'b0;
        m_from_s = 1'b0;
        s_load   = 1'b0;
        m_vld_n  = m_vld;
        s_vld_n  = s_vld;
        if (i_flush) begin
            m_vld_n = 1'b0;
            s_vld_n = 1'b0;
        end else if (emit) begin
            // When S is valid, ready is low, so no accept can arrive.
            if (s_vld) begin
                m_load   = 1'b1;
                m_from_s = 1'b1;
                m_vld_n  = 1'b1;
                s_vld_n  = 1'b0;
            end else if (accept) begin
                m_load  = 1'b1;
                m_vld_n = 1'b1;
            end else begin
                m_vld_n = 1'b0;
            end
        end else if (accept) begin
            if (!m_vld) begin
                m_load  = 1'b1;
                m_vld_n = 1'b1;
            end else begin
                s_load  = 1'b1;
                s_vld_n = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_vld <= 1'b0;
            s_vld <= 1'b0;
            m_q   <= '0;
            s_q   <= '0;
        end else begin
            m_vld <= m_vld_n;
            s_vld <= s_vld_n;
            if (m_load) m_q <= m_from_s ? s_q : in_ent;
            if (s_load) s_q <= in_ent;
        end
    end
`else
    assign o_ready_EX = (!m_vld | i_ready_MEM) & !i_rst;

    // An accept is only possible when M is empty or is draining this cycle.
    always_comb begin
        m_load  = 1'b0;
        m_vld_n = m_vld;
        if (i_flush) begin
            m_vld_n = 1'b0;
        end else if (accept) begin
            m_load  = 1'b1;
            m_vld_n = 1'b1;
        end else if (emit) begin
            m_vld_n = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            m_vld <= 1'b0;
            m_q   <= '0;
        end else begin
            m_vld <= m_vld_n;
            if (m_load) m_q <= in_ent;
        end
    end
`endif

    assign o_valid_MEM      = m_vld;
    assign o_alu_result_MEM = m_q.alu;
    assign o_rs2_data_MEM   = m_q.rs2;
    assign o_pc4_MEM        = m_q.pc4;
    assign o_write_reg_MEM  = m_q.rd;
    // Gate the bits the forwarding and hazard logic match on.
    assign o_regwrite_MEM   = m_q.ctrl[8] & m_vld;
    assign o_memtoreg_MEM   = m_q.ctrl[7];
    assign o_memread_MEM    = m_q.ctrl[6] & m_vld;
    assign o_memwrite_MEM   = m_q.ctrl[5] & m_vld;
    assign o_wb_MEM         = m_q.ctrl[4];
    assign o_slt_MEM        = m_q.ctrl[3];
    assign o_jump_MEM       = m_q.ctrl[2];
    assign o_funct3_MEM     = m_q.ctrl[1:0];

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// tb_ex_mem_pipe_reg: self-checking bench for ex_mem_pipe_reg.
// The reference model is an in-order queue of held instructions.
//   - Capacity is 2 with the skid entry and 1 without it.
//   - The queue head is what MEM must see.
// Fixed vector tables cover streaming, bubbles and control passthrough.
// Hand-written sequences cover backpressure and flush.
// A random phase runs last.
module tb_ex_mem_pipe_reg;
    localparam int XLEN = 32;
`ifdef SKID_BUFFER_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] rs2;
        logic [31:0] pc4;
        logic [4:0]  rd;
        logic [8:0]  ctrl;
    } ent_t;

    typedef struct {
        logic        v;
        logic        r;
        ent_t        e;
        logic        ev;
        logic [4:0]  erd;
        logic [31:0] ealu;
        logic [31:0] epc4;
        logic [8:0]  ectrl;
    } vec_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            i_flush, i_valid_EX, i_ready_MEM;
    logic            o_ready_EX, o_valid_MEM;
    logic [XLEN-1:0] i_alu, i_rs2, i_pc4;
    logic [4:0]      i_rd;
    logic [8:0]      i_ctrl;
    logic [XLEN-1:0] o_alu, o_rs2, o_pc4;
    logic [4:0]      o_rd;
    logic            o_rw, o_mtr, o_mr, o_mw, o_wb, o_slt, o_jmp;
    logic [1:0]      o_f3;

    int checks = 0;
    int errors = 0;
    ent_t q[$];
    logic [4:0] emitted[$];
    logic last_acc;
    vec_t tbl[$];

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.XLEN(XLEN)) dut (
        .i_clk(clk), .i_rst(rst), .i_flush(i_flush),
        .i_valid_EX(i_valid_EX), .o_ready_EX(o_ready_EX),
        .i_alu_result_EX(i_alu), .i_rs2_data_EX(i_rs2), .i_pc4_EX(i_pc4),
        .i_write_reg_EX(i_rd), .i_ctrl_EX(i_ctrl),
        .o_valid_MEM(o_valid_MEM), .i_ready_MEM(i_ready_MEM),
        .o_alu_result_MEM(o_alu), .o_rs2_data_MEM(o_rs2), .o_pc4_MEM(o_pc4),
        .o_write_reg_MEM(o_rd), .o_regwrite_MEM(o_rw), .o_memtoreg_MEM(o_mtr),
        .o_memread_MEM(o_mr), .o_memwrite_MEM(o_mw), .o_wb_MEM(o_wb),
        .o_slt_MEM(o_slt), .o_jump_MEM(o_jmp), .o_funct3_MEM(o_f3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [8:0] out_ctrl();
        return {o_rw, o_mtr, o_mr, o_mw, o_wb, o_slt, o_jmp, o_f3};
    endfunction

    function automatic ent_t mk(input logic [4:0] rd, input logic [31:0] alu,
                                input logic [31:0] pc4, input logic [8:0] ctrl);
        ent_t e;
        e.rd = rd; e.alu = alu; e.rs2 = alu ^ 32'h5A5A_0000; e.pc4 = pc4; e.ctrl = ctrl;
        return e;
    endfunction

    function automatic ent_t rnd_ent();
        ent_t e;
        e.alu = $urandom; e.rs2 = $urandom; e.pc4 = $urandom;
        e.rd = 5'($urandom); e.ctrl = 9'($urandom);
        return e;
    endfunction

    // Compare every output against the queue head.
    task automatic check_model();
        chk("valid", o_valid_MEM, q.size() > 0);
        if (q.size() > 0) begin
            chk("rd", o_rd, q[0].rd);
            chk("alu", o_alu, q[0].alu);
            chk("rs2", o_rs2, q[0].rs2);
            chk("pc4", o_pc4, q[0].pc4);
            chk("ctrl", out_ctrl(), q[0].ctrl);
        end else begin
            chk("bubble_gated", {o_rw, o_mr, o_mw}, 3'b000);
        end
    endtask

    // Run one clock cycle with the given inputs and update the model.
    task automatic step(input logic v, input logic r, input logic f, input ent_t e);
        logic mrdy, acc, emi;
        @(negedge clk);
        i_valid_EX = v; i_ready_MEM = r; i_flush = f;
        i_alu = e.alu; i_rs2 = e.rs2; i_pc4 = e.pc4; i_rd = e.rd; i_ctrl = e.ctrl;
        #1;
        if (rst) mrdy = 1'b0;
        else if (SKID) mrdy = q.size() < 2;
        else mrdy = (q.size() == 0) || r;
        chk("ready_EX", o_ready_EX, mrdy);
        acc = v & mrdy;
        emi = (q.size() > 0) & r;
        last_acc = acc & !rst & !f;
        if (emi && !rst && !f) emitted.push_back(q[0].rd);
        @(posedge clk);
        #1;
        if (rst || f) q.delete();
        else begin
            if (emi) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        check_model();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, '0);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].r, 1'b0, tbl[i].e);
            chk($sformatf("tbl%0d_valid", i), o_valid_MEM, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("tbl%0d_rd", i), o_rd, tbl[i].erd);
                chk($sformatf("tbl%0d_alu", i), o_alu, tbl[i].ealu);
                chk($sformatf("tbl%0d_pc4", i), o_pc4, tbl[i].epc4);
                chk($sformatf("tbl%0d_ctrl", i), out_ctrl(), tbl[i].ectrl);
            end else begin
                chk($sformatf("tbl%0d_gated", i), {o_rw, o_mr, o_mw}, 3'b000);
            end
        end
        tbl.delete();
    endtask

    task automatic add(input logic v, input logic r, input ent_t e, input logic ev,
                       input logic [4:0] erd, input logic [31:0] ealu,
                       input logic [31:0] epc4, input logic [8:0] ectrl);
        vec_t t;
        t.v = v; t.r = r; t.e = e; t.ev = ev; t.erd = erd; t.ealu = ealu;
        t.epc4 = epc4; t.ectrl = ectrl;
        tbl.push_back(t);
    endtask

    initial begin
        int idx, stall_acc;
        ent_t src[$];
        rst = 1'b1; i_flush = 0; i_valid_EX = 0; i_ready_MEM = 0;
        i_alu = 0; i_rs2 = 0; i_pc4 = 0; i_rd = 0; i_ctrl = 0;
        last_acc = 0;

        // 1: reset with EX offering.
        step(1'b1, 1'b1, 1'b0, mk(5'd9, 32'h99, 32'h4, 9'h100));
        step(1'b1, 1'b1, 1'b0, mk(5'd9, 32'h99, 32'h4, 9'h100));
        chk("rst_valid", o_valid_MEM, 1'b0);
        chk("rst_regwrite", o_rw, 1'b0);
        chk("rst_payload", {o_alu, o_rd, out_ctrl()}, '0);
        rst = 1'b0;
        @(negedge clk);
        i_valid_EX = 1'b0; i_ready_MEM = 1'b1;
        #1 chk("ready_after_rst", o_ready_EX, 1'b1);

        // 2: streaming rd=1..4; 5: bubble after rd=5; 6: ctrl passthrough.
        for (int k = 1; k <= 4; k++)
            add(1, 1, mk(5'(k), 32'(k * 16), 32'h4, 9'h100),
                1, 5'(k), 32'(k * 16), 32'h4, 9'h100);
        add(0, 1, '0, 0, 0, 0, 0, 0);
        add(1, 1, mk(5'd5, 32'h50, 32'h8, 9'h100), 1, 5'd5, 32'h50, 32'h8, 9'h100);
        add(0, 1, '0, 0, 0, 0, 0, 0);
        add(1, 1, mk(5'd0, 32'h1, 32'h104, 9'h00C), 1, 5'd0, 32'h1, 32'h104, 9'h00C);
        add(1, 1, mk(5'd6, 32'h60, 32'h0, 9'h142), 1, 5'd6, 32'h60, 32'h0, 9'h142);
        add(0, 1, '0, 0, 0, 0, 0, 0);
        run_table();

        // 3: backpressure while EX streams rd 1..6.
        emitted.delete();
        for (int k = 1; k <= 6; k++) src.push_back(mk(5'(k), 32'(k * 16), 32'h0, 9'h100));
        idx = 0; stall_acc = 0;
        for (int c = 0; c < 20; c++) begin
            logic r;
            r = !(c >= 2 && c <= 4);
            if (idx < src.size()) step(1'b1, r, 1'b0, src[idx]);
            else step(1'b0, r, 1'b0, '0);
            if (last_acc) idx++;
            if (!r && last_acc) stall_acc++;
            if (c >= 2 && c <= 4) chk("stall_alu_held", o_alu, 32'h20);
        end
        chk("bp_extra_accepts", stall_acc, SKID ? 1 : 0);
        chk("bp_count", emitted.size(), 6);
        foreach (emitted[i]) chk($sformatf("bp_order%0d", i), emitted[i], 5'(i + 1));

        // 4: fill the block, then flush with EX offering.
        emitted.delete();
        step(1'b1, 1'b0, 1'b0, mk(5'd7, 32'h70, 32'h0, 9'h100));
        step(1'b1, 1'b0, 1'b0, mk(5'd8, 32'h80, 32'h0, 9'h100));
        step(1'b1, 1'b0, 1'b1, mk(5'd9, 32'h90, 32'h0, 9'h100));
        chk("flush_valid", o_valid_MEM, 1'b0);
        chk("flush_regwrite", o_rw, 1'b0);
        for (int c = 0; c < 4; c++) begin
            step(1'b0, 1'b1, 1'b0, '0);
            chk("post_flush_valid", o_valid_MEM, 1'b0);
        end
        chk("flush_no_emit", emitted.size(), 0);

        // Random traffic against the queue model.
        for (int c = 0; c < 400; c++)
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                 1'($urandom_range(0, 19) == 0), rnd_ent());
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
